// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the serial boot loader.
//   boot_state_e : loader FSM states
//   CHK_W        : checksum width (bits)
//   WORD_W       : memory word width (bits)
//   state_busy() : true while a frame is being received
package boot_pkg;

   localparam int CHK_W  = 8;
   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CNT_LO  = 3'd1,
      DATA_HI = 3'd2,
      DATA_LO = 3'd3,
      CHECK   = 3'd4,
      DONE    = 3'd5,
      ERROR   = 3'd6
   } boot_state_e;

   function automatic logic state_busy(input boot_state_e s);
      return !((s == IDLE) || (s == DONE) || (s == ERROR));
   endfunction

endpackage

// File: rtl/boot_idle_timer.sv
// boot_idle_timer: counts idle cycles inside a frame.
//   clk, reset : system clock, synchronous active-high reset
//   clear_i    : restart the count (a byte arrived)
//   en_i       : count only while a frame is in progress
//   expired_o  : one-cycle pulse on the cycle the count reaches TIMEOUT
module boot_idle_timer #(
   parameter logic [23:0] TIMEOUT = 24'd1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   logic [23:0] cnt_q, cnt_d;
   logic        hit;

   // A byte arriving in the same cycle wins over expiry.
   assign hit       = en_i && !clear_i && (cnt_q == TIMEOUT - 24'd1);
   assign expired_o = hit;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || hit || !en_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 24'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a program image over a byte stream, writes it into
// memory port B and releases the CPU once the checksum verifies.
// Frame (big-endian): CNT_HI, CNT_LO, N x (HI, LO), CHK; all bytes sum to 0 mod 256.
//   clk, reset   : system clock, synchronous active-high reset
//   rx_valid     : one-cycle strobe qualifying rx_byte
//   rx_byte      : received byte
//   b_address    : memory port B word address
//   b_writeData  : memory port B write data
//   b_we         : memory port B write enable, one-cycle pulse per word
//   cpu_reset    : holds the CPU in reset until a good image is loaded
//   busy         : frame in progress
//   done         : image loaded and checksum good (sticky until reset)
//   error        : checksum or length failure (sticky until reset)
// Handshake: rx_valid has no back-pressure; every strobe is consumed in the
// cycle it is presented, including back-to-back strobes.
module boot_loader
   import boot_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] MAX_WORDS = 16'd1024,
   parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic [15:0] b_address,
   output logic [15:0] b_writeData,
   output logic        b_we,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error
);

   boot_state_e         state_q, state_d;
   logic [CHK_W-1:0]    sum_q, sum_d;
   logic [15:0]         idx_q, idx_d;
   logic [15:0]         n_q, n_d;
   logic [7:0]          hi_q, hi_d;
   logic [15:0]         addr_q, addr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                expired;

   boot_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (rx_valid),
      .en_i      (busy_q),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      n_d     = n_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;

      if (expired) begin
         // Abandon the partial frame; words already written stay in memory.
         state_d = IDLE;
         sum_d   = '0;
         idx_d   = '0;
      end else if (rx_valid) begin
         case (state_q)
            IDLE: begin
               n_d     = {rx_byte, 8'h00};
               sum_d   = rx_byte;
               state_d = CNT_LO;
            end
            CNT_LO: begin
               n_d   = {n_q[15:8], rx_byte};
               sum_d = sum_q + rx_byte;
               idx_d = '0;
               if (n_d > MAX_WORDS) begin
                  state_d = ERROR;
               end else if (n_d == 16'd0) begin
                  state_d = CHECK;
               end else begin
                  state_d = DATA_HI;
               end
            end
            DATA_HI: begin
               hi_d    = rx_byte;
               sum_d   = sum_q + rx_byte;
               state_d = DATA_LO;
            end
            DATA_LO: begin
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + idx_q;
               wdata_d = {hi_q, rx_byte};
               idx_d   = idx_q + 16'd1;
               sum_d   = sum_q + rx_byte;
               state_d = (idx_d == n_q) ? CHECK : DATA_HI;
            end
            CHECK: begin
               sum_d   = sum_q + rx_byte;
               state_d = (sum_d == '0) ? DONE : ERROR;
            end
            default: begin
               // DONE and ERROR hold until reset.
               state_d = state_q;
            end
         endcase
      end

      // Status outputs are registered views of the next state.
      busy_d      = state_busy(state_d);
      done_d      = (state_d == DONE);
      error_d     = (state_d == ERROR);
      cpu_reset_d = (state_d != DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         idx_q       <= '0;
         n_q         <= '0;
         hi_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         n_q         <= n_d;
         hi_q        <= hi_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign b_address   = addr_q;
   assign b_writeData = wdata_q;
   assign b_we        = we_q;
   assign cpu_reset   = cpu_reset_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule
